ucsbece154b_line_fill: RTL and testbench

Reader-side consumer for the instruction/data refill FIFO. Pops `BLOCK_WORDS` consecutive words from the FIFO's pop interface, starting from a critical-word offset. Places each word in its slot of a cache-line buffer and forwards the critical word early. Presents the assembled line to the cache through a valid/ready handshake.

---
 rtl/ucsbece154b_mem_pkg.sv | 22 ++
 rtl/ucsbece154b_wrap_counter.sv | 31 +++
 rtl/ucsbece154b_line_fill.sv | 115 +++++++++++
 tb/tb_ucsbece154b_line_fill.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ucsbece154b_mem_pkg
//  Description : Shared memory-subsystem types and default geometry used by
//                the line-fill engine and the cache controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ucsbece154b_mem_pkg;

    // Default line geometry shared by the fill engine and the cache controller
    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_BLOCK_WORDS = 4;

    // Line-fill sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } fill_state_e;

endpackage
`default_nettype wire

// File: rtl/ucsbece154b_wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ucsbece154b_wrap_counter
//  Description : Slot index with synchronous load and increment. The index
//                wraps modulo 2**WIDTH through natural overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154b_wrap_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Load takes priority; increment rolls over from all-ones back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ucsbece154b_line_fill.sv
`default_nettype none
// ============================================================================
//  Module      : ucsbece154b_line_fill
//  Description : Pops one cache line worth of words from the refill FIFO,
//                starting at the critical word, forwards that word early and
//                hands the assembled line to the cache via valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154b_line_fill
    import ucsbece154b_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int OW          = $clog2(BLOCK_WORDS)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [OW-1:0]                     first_word_i,
    input  logic [DATA_WIDTH-1:0]             fifo_data_i,
    input  logic                              fifo_valid_i,
    output logic                              fifo_pop_o,
    output logic [DATA_WIDTH-1:0]             crit_word_o,
    output logic                              crit_valid_o,
    output logic [DATA_WIDTH*BLOCK_WORDS-1:0] line_o,
    output logic                              line_valid_o,
    input  logic                              line_ready_i,
    output logic                              busy_o
);

    // Count value of the last word of a line
    localparam logic [OW:0] CNT_LAST = (OW+1)'(BLOCK_WORDS - 1);

    fill_state_e                           state_q;
    fill_state_e                           state_d;
    logic [OW:0]                           cnt_q;
    logic [OW-1:0]                         slot_q;
    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] line_q;
    logic [DATA_WIDTH-1:0]                 crit_word_q;
    logic                                  crit_valid_q;
    logic                                  accept_start;

    assign accept_start = (state_q == IDLE) && start_i;

    // Slot index: starts at the critical word and wraps around the line
    ucsbece154b_wrap_counter #(
        .WIDTH (OW)
    ) u_slot_counter (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .load       (accept_start),
        .load_value (first_word_i),
        .inc        (fifo_pop_o),
        .count      (slot_q)
    );

    // Next-state and handshake outputs; pops are gated by FIFO validity
    always_comb begin
        state_d      = state_q;
        fifo_pop_o   = 1'b0;
        line_valid_o = 1'b0;
        busy_o       = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                fifo_pop_o = fifo_valid_i;
                if (fifo_valid_i && (cnt_q == CNT_LAST)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                line_valid_o = 1'b1;
                if (line_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, word count, line buffer and critical-word capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            crit_word_q  <= '0;
            crit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            crit_valid_q <= fifo_pop_o && (cnt_q == '0);
            if (accept_start) begin
                cnt_q <= '0;
            end else if (fifo_pop_o) begin
                cnt_q          <= cnt_q + 1'b1;
                line_q[slot_q] <= fifo_data_i;
                if (cnt_q == '0) begin
                    crit_word_q <= fifo_data_i;
                end
            end
        end
    end

    assign line_o       = line_q;
    assign crit_word_o  = crit_word_q;
    assign crit_valid_o = crit_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_line_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ucsbece154b_line_fill
//  Description : Self-checking bench for the line-fill engine: directed
//                vector table, hand-written corner sequences and randomized
//                fills checked against a transaction-level line model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ucsbece154b_line_fill;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   first_word;
    logic [31:0]  fifo_data;
    logic         fifo_valid;
    logic         fifo_pop;
    logic [31:0]  crit_word;
    logic         crit_valid;
    logic [127:0] line;
    logic         line_valid;
    logic         line_ready;
    logic         busy;

    int vectors;
    int miscompares;

    ucsbece154b_line_fill #(
        .DATA_WIDTH  (32),
        .BLOCK_WORDS (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .first_word_i (first_word),
        .fifo_data_i  (fifo_data),
        .fifo_valid_i (fifo_valid),
        .fifo_pop_o   (fifo_pop),
        .crit_word_o  (crit_word),
        .crit_valid_o (crit_valid),
        .line_o       (line),
        .line_valid_o (line_valid),
        .line_ready_i (line_ready),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       first;
        logic [3:0][31:0] words;
        logic [127:0]     exp_line;
    } fill_vec_t;

    fill_vec_t tbl [4];

    // Word i of a fill lands in slot (first + i) mod 4
    function automatic logic [127:0] assemble(input logic [1:0] first, input logic [3:0][31:0] ws);
        logic [127:0] l;
        l = '0;
        for (int i = 0; i < 4; i++) begin
            l[((int'(first) + i) % 4) * 32 +: 32] = ws[i];
        end
        return l;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back fill with exact cycle-by-cycle timing checks
    task automatic run_b2b(input logic [1:0] first, input logic [3:0][31:0] ws, input logic [127:0] exp_line);
        start = 1'b1; first_word = first; fifo_valid = 1'b0; line_ready = 1'b0;
        #1;
        check("b2b_idle_busy", busy, 1'b0);
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fifo_valid = 1'b1; fifo_data = ws[i];
            #1;
            check("b2b_pop", fifo_pop, 1'b1);
            check("b2b_crit_valid", crit_valid, (i == 1));
            if (i == 1) check("b2b_crit_word", crit_word, ws[0]);
            check("b2b_line_valid_early", line_valid, 1'b0);
            cyc();
        end
        fifo_valid = 1'b1; fifo_data = 32'hFFFF_0000;
        #1;
        check("b2b_hold_pop", fifo_pop, 1'b0);
        check("b2b_line_valid", line_valid, 1'b1);
        check("b2b_line", line, exp_line);
        check("b2b_crit_hold", crit_word, ws[0]);
        line_ready = 1'b1;
        cyc();
        line_ready = 1'b0; fifo_valid = 1'b0;
        #1;
        check("b2b_back_idle", busy, 1'b0);
        check("b2b_line_valid_off", line_valid, 1'b0);
    endtask

    logic [3:0][31:0] ws;
    logic [1:0]       fw;
    int               taken;
    int               guard;
    int               delay;
    logic             crit_due;
    logic [127:0]     exp_l;

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; first_word = '0; fifo_data = '0;
        fifo_valid = 1'b0; line_ready = 1'b0;

        tbl[0] = '{first: 2'd0, words: {32'h44, 32'h33, 32'h22, 32'h11},
                   exp_line: 128'h00000044_00000033_00000022_00000011};
        tbl[1] = '{first: 2'd2, words: {32'hD, 32'hC, 32'hB, 32'hA},
                   exp_line: 128'h0000000B_0000000A_0000000D_0000000C};
        tbl[2] = '{first: 2'd3, words: {32'h9ABCDEF0, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF},
                   exp_line: 128'hDEADBEEF_9ABCDEF0_12345678_CAFEF00D};
        tbl[3] = '{first: 2'd1, words: {32'h55555555, 32'hAAAAAAAA, 32'h00000000, 32'hFFFFFFFF},
                   exp_line: 128'hAAAAAAAA_00000000_FFFFFFFF_55555555};

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom_range(0, 1)); first_word = 2'($urandom_range(0, 3));
            fifo_valid = 1'($urandom_range(0, 1)); fifo_data = $urandom;
            line_ready = 1'($urandom_range(0, 1));
            #1;
            check("rst_pop", fifo_pop, 1'b0);
            check("rst_crit_valid", crit_valid, 1'b0);
            check("rst_crit_word", crit_word, 32'h0);
            check("rst_line", line, 128'h0);
            check("rst_line_valid", line_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            cyc();
        end
        start = 1'b0; fifo_valid = 1'b0; line_ready = 1'b0;
        rst_n = 1'b1;
        cyc();
        #1;
        check("post_rst_busy", busy, 1'b0);

        // Directed vector table
        for (int v = 0; v < 4; v++) begin
            run_b2b(tbl[v].first, tbl[v].words, tbl[v].exp_line);
        end

        // FIFO bubble after second pop, then long HOLD stall with start pulsed
        ws = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        exp_l = assemble(2'd0, ws);
        start = 1'b1; first_word = 2'd0; fifo_valid = 1'b0;
        cyc();
        start = 1'b0;
        fifo_valid = 1'b1; fifo_data = ws[0]; #1;
        check("bub_pop1", fifo_pop, 1'b1);
        cyc();
        fifo_data = ws[1]; #1;
        check("bub_pop2", fifo_pop, 1'b1);
        check("bub_crit_valid", crit_valid, 1'b1);
        check("bub_crit_word", crit_word, ws[0]);
        cyc();
        for (int i = 0; i < 2; i++) begin
            fifo_valid = 1'b0; fifo_data = 32'hBAD0_BAD0; #1;
            check("bub_gap_pop", fifo_pop, 1'b0);
            check("bub_gap_busy", busy, 1'b1);
            check("bub_gap_line_valid", line_valid, 1'b0);
            check("bub_gap_crit_valid", crit_valid, 1'b0);
            cyc();
        end
        for (int i = 2; i < 4; i++) begin
            fifo_valid = 1'b1; fifo_data = ws[i]; #1;
            check("bub_pop_late", fifo_pop, 1'b1);
            check("bub_line_valid_early", line_valid, 1'b0);
            cyc();
        end
        for (int i = 0; i < 5; i++) begin
            line_ready = 1'b0; fifo_valid = 1'b1; start = (i == 2);
            #1;
            check("stall_line_valid", line_valid, 1'b1);
            check("stall_line", line, exp_l);
            check("stall_pop", fifo_pop, 1'b0);
            cyc();
        end
        start = 1'b0; line_ready = 1'b1; #1;
        check("stall_line_valid_last", line_valid, 1'b1);
        cyc();
        line_ready = 1'b0; fifo_valid = 1'b1; #1;
        check("stall_idle", busy, 1'b0);
        check("stall_idle_pop", fifo_pop, 1'b0);
        cyc();
        #1;
        check("stall_start_not_queued", busy, 1'b0);
        fifo_valid = 1'b0;

        // Reset after two pops discards the partial fill
        start = 1'b1; first_word = 2'd0;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fifo_valid = 1'b1; fifo_data = 32'h7700_0000 + i;
            cyc();
        end
        fifo_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_pop", fifo_pop, 1'b0);
        check("midrst_line", line, 128'h0);
        check("midrst_crit_word", crit_word, 32'h0);
        check("midrst_crit_valid", crit_valid, 1'b0);
        cyc();
        fifo_valid = 1'b0;
        rst_n = 1'b1;
        cyc();
        run_b2b(2'd1, {32'h4, 32'h3, 32'h2, 32'h1},
                128'h00000003_00000002_00000001_00000004);

        // Randomized fills against the transaction-level line model
        for (int f = 0; f < 25; f++) begin
            fw = 2'($urandom_range(0, 3));
            taken = 0; guard = 0; crit_due = 1'b0; ws = '0;
            start = 1'b1; first_word = fw; fifo_valid = 1'b0; line_ready = 1'b0;
            #1;
            check("rnd_idle_busy", busy, 1'b0);
            cyc();
            start = 1'b0;
            while (taken < 4 && guard < 200) begin
                fifo_valid = ($urandom_range(0, 9) < 7);
                fifo_data  = $urandom;
                start      = 1'($urandom_range(0, 1));
                line_ready = 1'($urandom_range(0, 1));
                #1;
                check("rnd_pop", fifo_pop, fifo_valid);
                check("rnd_crit_valid", crit_valid, crit_due);
                if (crit_due) check("rnd_crit_word", crit_word, ws[0]);
                check("rnd_line_valid_early", line_valid, 1'b0);
                crit_due = fifo_valid && (taken == 0);
                if (fifo_valid) begin
                    ws[taken] = fifo_data;
                    taken++;
                end
                guard++;
                cyc();
            end
            if (taken < 4) begin
                miscompares++;
                $display("FAIL rnd_fill_bound: got %0d words expected 4", taken);
            end
            exp_l = assemble(fw, ws);
            delay = $urandom_range(0, 3);
            for (int d = 0; d <= delay; d++) begin
                fifo_valid = 1'($urandom_range(0, 1));
                start      = 1'($urandom_range(0, 1));
                line_ready = (d == delay);
                #1;
                check("rnd_line_valid", line_valid, 1'b1);
                check("rnd_line", line, exp_l);
                check("rnd_hold_pop", fifo_pop, 1'b0);
                check("rnd_hold_crit_valid", crit_valid, crit_due);
                check("rnd_hold_crit_word", crit_word, ws[0]);
                crit_due = 1'b0;
                cyc();
            end
            start = 1'b0; line_ready = 1'b0; fifo_valid = 1'b0;
            #1;
            check("rnd_back_idle", busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
